// File: rtl/mdsa_pkg.sv
// Shared definitions for the parametrised shearsort grid: FSM encoding,
// phase bookkeeping and element/cell index helpers.
package mdsa_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROW  = 2'd1,
      COL  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Ceiling log2; usable in constant expressions.
   function automatic int log2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Low bit of element k in a flat vector of dw-bit elements.
   function automatic int elem_lo(input int k, input int dw);
      return k * dw;
   endfunction

   // Linear element index of grid cell (r,c) in an n-wide grid.
   function automatic int cell_idx(input int r, input int c, input int n);
      return r * n + c;
   endfunction

   // Number of phases for an n x n grid: LOGN+1 row phases interleaved with LOGN column phases.
   function automatic int phases_for(input int n);
      return 2 * log2(n) + 1;
   endfunction

   localparam int DEF_N    = 8;
   localparam int DEF_LOGN = log2(DEF_N);
   localparam int PHASES   = 2 * DEF_LOGN + 1;

endpackage

// File: rtl/mdsa_shearsort_param_if.sv
// Start/rdy/output_enable bundle of the shearsort block, plus its FSM state
// for observation.
interface mdsa_shearsort_param_if #(
   parameter int N  = 8,
   parameter int DW = 32
);
   import mdsa_pkg::*;

   // Handshake: a start is taken on a rising clk edge where en=1 and rdy=1;
   // data_in and desc are sampled on that same edge. output_enable stays high,
   // with data_out stable, until the next accepted start or reset.
   logic              en;
   logic              start;
   logic              desc;
   logic [N*N*DW-1:0] data_in;
   logic [N*N*DW-1:0] data_out;
   logic              output_enable;
   logic              rdy;
   state_t            fsm_state;

   modport master (
      output en, start, desc, data_in,
      input  data_out, output_enable, rdy, fsm_state
   );

   modport slave (
      input  en, start, desc, data_in,
      output data_out, output_enable, rdy, fsm_state
   );

endinterface

// File: rtl/mdsa_cas.sv
// Compare-exchange cell: orders the pair (a,b) ascending when dir=0 and
// descending when dir=1; equal keys pass straight through.
module mdsa_cas #(
   parameter int DW = 32
) (
   input  logic [DW-1:0]       a,
   input  logic [DW-1:0]       b,
   input  logic                dir,
   output logic [1:0][DW-1:0]  lo_or_hi
);

   logic swap;

   assign swap        = dir ? (a < b) : (a > b);
   assign lo_or_hi[0] = swap ? b : a;
   assign lo_or_hi[1] = swap ? a : b;

endmodule

// File: rtl/mdsa_shearsort_param.sv
// N x N shearsort engine: snake-ordered row phases alternating with column
// phases, each an N-step odd-even transposition pass, then an un-snaked output.
module mdsa_shearsort_param
   import mdsa_pkg::*;
#(
   parameter int N    = 8,
   parameter int DW   = 32,
   parameter int LOGN = $clog2(N)
) (
   input logic                    clk,
   input logic                    rst,
   mdsa_shearsort_param_if.slave  bus
);

   localparam int NPHASES = phases_for(N);
   localparam int PH_W    = log2(NPHASES);

   state_t            state;
   logic [LOGN-1:0]   step_cnt;
   logic [PH_W-1:0]   phase_cnt;
   logic              desc_q;
   logic              fin_q;
   logic [N*N*DW-1:0] data_out_q;
   logic              oe_q;
   logic              rdy_q;

   logic [DW-1:0]          grid     [N][N];
   logic [DW-1:0]          grid_nxt [N][N];
   logic [N*N*DW-1:0]      out_flat;

   // Lane i is row i during ROW and column i during COL; pair j joins
   // positions j and j+1 along that lane.
   logic [DW-1:0]          cas_a   [N][N-1];
   logic [DW-1:0]          cas_b   [N][N-1];
   logic [1:0][DW-1:0]     cas_out [N][N-1];
   logic                   cas_dir [N];

   for (genvar i = 0; i < N; i++) begin : g_lane
      assign cas_dir[i] = (state == COL) ? desc_q : ((i % 2 == 1) ^ desc_q);
      for (genvar j = 0; j < N - 1; j++) begin : g_pair
         assign cas_a[i][j] = (state == COL) ? grid[j][i]   : grid[i][j];
         assign cas_b[i][j] = (state == COL) ? grid[j+1][i] : grid[i][j+1];
         mdsa_cas #(.DW(DW)) u_cas (
            .a        (cas_a[i][j]),
            .b        (cas_b[i][j]),
            .dir      (cas_dir[i]),
            .lo_or_hi (cas_out[i][j])
         );
      end
   end

   // Only pairs whose left index has the step's parity are active; others hold.
   always_comb begin
      logic          upd;
      logic [DW-1:0] v;
      upd      = 1'b0;
      v        = '0;
      grid_nxt = grid;
      for (int i = 0; i < N; i++) begin
         for (int p = 0; p < N; p++) begin
            upd = 1'b0;
            v   = '0;
            if (p < N - 1 && p[0] == step_cnt[0]) begin
               upd = 1'b1;
               v   = cas_out[i][p][0];
            end else if (p > 0 && p[0] != step_cnt[0]) begin
               upd = 1'b1;
               v   = cas_out[i][p-1][1];
            end
            if (upd) begin
               if (state == COL) grid_nxt[p][i] = v;
               else              grid_nxt[i][p] = v;
            end
         end
      end
   end

   always_comb begin
      out_flat = '0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            out_flat[elem_lo(cell_idx(r, c, N), DW) +: DW] =
               (r % 2 == 0) ? grid[r][c] : grid[r][N-1-c];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         step_cnt   <= '0;
         phase_cnt  <= '0;
         desc_q     <= 1'b0;
         fin_q      <= 1'b0;
         data_out_q <= '0;
         oe_q       <= 1'b0;
         rdy_q      <= 1'b1;
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               grid[r][c] <= '0;
      end else if (bus.en) begin
         case (state)
            IDLE, DONE: begin
               // fin_q publishes the grid one cycle after the last step.
               if (fin_q) begin
                  data_out_q <= out_flat;
                  oe_q       <= 1'b1;
                  fin_q      <= 1'b0;
               end
               if (bus.start) begin
                  for (int r = 0; r < N; r++)
                     for (int c = 0; c < N; c++)
                        grid[r][c] <= bus.data_in[elem_lo(cell_idx(r, c, N), DW) +: DW];
                  desc_q    <= bus.desc;
                  step_cnt  <= '0;
                  phase_cnt <= '0;
                  state     <= ROW;
                  oe_q      <= 1'b0;
                  rdy_q     <= 1'b0;
                  fin_q     <= 1'b0;
               end
            end
            ROW, COL: begin
               grid <= grid_nxt;
               if (step_cnt == LOGN'(N - 1)) begin
                  step_cnt <= '0;
                  if (phase_cnt == PH_W'(NPHASES - 1)) begin
                     state <= DONE;
                     rdy_q <= 1'b1;
                     fin_q <= 1'b1;
                  end else begin
                     phase_cnt <= phase_cnt + 1'b1;
                     state     <= phase_cnt[0] ? ROW : COL;
                  end
               end else begin
                  step_cnt <= step_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.data_out      = data_out_q;
   assign bus.output_enable = oe_q;
   assign bus.rdy           = rdy_q;
   assign bus.fsm_state     = state;

endmodule

// File: doc/mdsa_shearsort_param.md
Name: mdsa_shearsort_param

Overview:
- Parametrised successor to the fixed 8x8, 32-bit MDSA top.
- Sorts N*N unsigned DW-bit keys held in an N x N register grid using shearsort.
  - Row phases use snake ordering; column phases follow them.
  - Each phase is one odd-even transposition pass of N steps.
- Adds a runtime ascending/descending mode and a linear (un-snaked) output order.
- Drop-in replacement for the MDSA top: same start/rdy/output_enable handshake.

Parameters:
- N, 8, grid side; power of two, N >= 2.
- DW, 32, key width in bits (unsigned).
- LOGN, $clog2(N), derived; do not override.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  clock enable; when low, all state, counters and outputs hold.
- start  in  1  sampled on the rising edge of clk while en=1 and rdy=1; loads data_in and begins a sort.
- desc  in  1  mode, captured with start: 0 = ascending, 1 = descending.
- data_in  in  N*N*DW  element k = data_in[(k+1)*DW-1 : k*DW]; grid cell r=k/N, c=k%N.
- data_out  out  N*N*DW  sorted result, same slicing; element 0 is the minimum (ascending) or the maximum (descending).
- output_enable  out  1  high while data_out holds a valid completed sort.
- rdy  out  1  high when a start will be accepted.

Behaviour:
Reset (rst=1 at a clock edge, regardless of en):
- State goes to IDLE; grid and counters clear to 0.
- Outputs: data_out=0, output_enable=0, rdy=1.
- A reset mid-sort aborts the sort; no output_enable pulse is produced.

States: IDLE, ROW, COL, DONE. phase_cnt runs 0..2*LOGN; step_cnt runs 0..N-1.
- IDLE/DONE, start=1:
  - Load the grid from data_in and latch desc.
  - Clear both counters and go to ROW.
  - output_enable drops in the same cycle.
- start outside IDLE/DONE: ignored; in-flight data is unaffected.
- ROW/COL: one compare-exchange step per enabled cycle.
  - Even step_cnt compares pairs (0,1),(2,3),...
  - Odd step_cnt compares pairs (1,2),(3,4),...
  - Pairs do not wrap around.
- ROW ordering: row r is ordered left-to-right ascending iff (r even) XOR desc; otherwise descending.
- COL ordering: each column is ordered top-to-bottom ascending iff desc=0.
- Equal keys never swap.
- When step_cnt reaches N-1:
  - step_cnt returns to 0 and phase_cnt increments.
  - Next phase is ROW if the new phase_cnt is even, COL if odd.
  - After phase 2*LOGN (always a ROW phase), go to DONE.
- Entering DONE:
  - Register the un-snaked grid into data_out: element r*N+c = grid[r][c] for even r, grid[r][N-1-c] for odd r.
  - Set output_enable=1.
- DONE holds data_out and output_enable until the next accepted start or rst.
- rdy=1 exactly in IDLE and DONE.
- Latency: output_enable rises 1+(2*LOGN+1)*N enabled cycles after the start edge (57 for N=8, 7 for N=2).
  - Each en=0 cycle extends this by exactly one cycle.
- Comparisons are unsigned and full-width; no arithmetic, so no overflow.

Decomposition:
- Package mdsa_pkg holds:
  - the state encoding (IDLE, ROW, COL, DONE);
  - a log2 function;
  - slice/index helper functions for element k and cell (r,c);
  - localparam PHASES = 2*LOGN+1.
- Sub-module mdsa_cas (parameter DW): inputs a, b, dir; outputs lo_or_hi pair; purely combinational.
  - Instantiated in a generate grid for both row and column pairs; the top muxes the pair selection by state and step parity.

Test Plan:
- N=2, DW=8, data_in elements [4,3,2,1], desc=0, start one cycle -> output_enable rises 7 cycles after the start edge; data_out=[1,2,3,4]; rdy=1.
- N=8, DW=32, elements 63..0 (reverse), desc=0 -> output_enable at cycle 57; data_out element k = k. Repeat with desc=1 and elements 0..63 -> element k = 63-k.
- N=8, all 64 elements = 5, plus a second run with duplicates [7,7,3,3,...] -> correct sorted multiset; no X; stable count of each value.
- Start pulsed again at cycle 20 of a sort with different data -> ignored; result matches the first data set at cycle 57.
- en low for 10 cycles mid-sort -> grid and counters frozen; output_enable at cycle 67 with the correct result.
- rst asserted at cycle 30 -> next edge: data_out=0, output_enable=0, rdy=1. A fresh start afterwards sorts correctly.
